// File: rtl/pipeline_hazard_ctrl5.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl5
//
// Central stall/flush scheduler for the 5-stage pipeline
// (IF, ID, IDR, EXB, EXA/MEM/WB).
//
// Each cycle one of four modes applies, highest priority first:
//   1. Memory back-pressure (mem_busy): the whole pipeline holds.
//   2. Taken branch resolved in EXB: the PC is redirected and the three
//      younger stage registers (IF, ID, IDR) are flushed.
//   3. Load-use bubble: the PC, IF and ID hold and IDR receives a bubble.
//      Bubbles continue for LOAD_USE_BUBBLES cycles per hazard.
//   4. Normal: no control is asserted.
//
// All control outputs are combinational from the current state and the
// inputs, so they take effect at the very next edge. While reset is high,
// every control output is forced low.
//
// Parameters
//   LOAD_USE_BUBBLES  bubbles inserted per load-use hazard (legal 1..7)
//   CNT_W             width of the performance counters
//
// Ports
//   clk                   clock, all state updates on the rising edge
//   reset                 synchronous, active-high reset
//   mem_busy              data memory not ready, hold the whole pipeline
//   branch_taken_EXB      taken branch/jump flag from EXB
//   rs1_ID, rs2_ID        source registers of the instruction in ID
//   rs1_used_ID/rs2_used_ID  the corresponding source is actually read
//   rd_IDR                destination register of the instruction in IDR
//   rf_wr_en_IDR          register-file write enable of the IDR instruction
//   dm_rd_ctrl_IDR        load control of the IDR instruction (non-zero = load)
//   pc_stall              hold the PC
//   stall_IF..stall_EXA   hold the named stage output registers
//   flush_IF..flush_IDR   clear the named stage output registers
//   redirect_en           PC loads the branch target at the next edge
//   lu_active             load-use FSM is inserting follow-up bubbles
//   stall_cycle_cnt       number of cycles with pc_stall asserted
//   redirect_cnt          number of accepted redirects
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl5 #(
    parameter int unsigned LOAD_USE_BUBBLES = 2,
    parameter int unsigned CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_busy,
    input  logic             branch_taken_EXB,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_IDR,
    input  logic             rf_wr_en_IDR,
    input  logic [2:0]       dm_rd_ctrl_IDR,
    output logic             pc_stall,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             stall_IDR,
    output logic             stall_EXB,
    output logic             stall_EXA,
    output logic             flush_IF,
    output logic             flush_ID,
    output logic             flush_IDR,
    output logic             redirect_en,
    output logic             lu_active,
    output logic [CNT_W-1:0] stall_cycle_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    typedef enum logic {
        RUN     = 1'b0,
        LU_WAIT = 1'b1
    } state_e;

    // The detection cycle is the first bubble, so LU_WAIT covers the
    // remaining LOAD_USE_BUBBLES-1 cycles.
    localparam logic [2:0] BUB_INIT     = 3'(LOAD_USE_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

    state_e           state_q, state_d;
    logic [2:0]       bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    // -----------------------------------------------------------------------
    // Load-use hazard detection
    // -----------------------------------------------------------------------
    // A load in IDR produces its value too late for the instruction in ID.
    // Writes to x0 are discarded by the register file and never hazard.
    logic is_load_IDR;
    logic rd_nonzero_IDR;
    logic rs1_hit;
    logic rs2_hit;
    logic lu_hz;

    assign is_load_IDR    = |dm_rd_ctrl_IDR;
    assign rd_nonzero_IDR = |rd_IDR;
    assign rs1_hit        = rs1_used_ID && (rs1_ID == rd_IDR);
    assign rs2_hit        = rs2_used_ID && (rs2_ID == rd_IDR);
    assign lu_hz          = is_load_IDR && rf_wr_en_IDR && rd_nonzero_IDR
                            && (rs1_hit || rs2_hit);

    // -----------------------------------------------------------------------
    // Mode selection (mutually exclusive, priority encoded)
    // -----------------------------------------------------------------------
    logic mode_mem;  // whole-pipeline freeze
    logic mode_br;   // redirect + flush of younger stages
    logic mode_lu;   // load-use bubble (detection cycle or LU_WAIT)

    // lu_hz is ignored once in LU_WAIT: the bubble count for the current
    // hazard is already committed, and the ID instruction is still the same.
    assign mode_mem = !reset && mem_busy;
    assign mode_br  = !reset && !mem_busy && branch_taken_EXB;
    assign mode_lu  = !reset && !mem_busy && !branch_taken_EXB
                      && ((state_q == LU_WAIT) || lu_hz);

    // -----------------------------------------------------------------------
    // Control outputs
    // -----------------------------------------------------------------------
    // During a load-use bubble IDR is flushed rather than held, so the
    // stall/flush pairs for the same register stay exclusive in every mode.
    assign pc_stall    = mode_mem || mode_lu;
    assign stall_IF    = mode_mem || mode_lu;
    assign stall_ID    = mode_mem || mode_lu;
    assign stall_IDR   = mode_mem;
    assign stall_EXB   = mode_mem;
    assign stall_EXA   = mode_mem;
    assign flush_IF    = mode_br;
    assign flush_ID    = mode_br;
    assign flush_IDR   = mode_br || mode_lu;
    assign redirect_en = mode_br;
    assign lu_active   = !reset && (state_q == LU_WAIT);

    assign stall_cycle_cnt = stall_cnt_q;
    assign redirect_cnt    = redirect_cnt_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        bub_cnt_d      = bub_cnt_q;
        stall_cnt_d    = stall_cnt_q + {{(CNT_W-1){1'b0}}, pc_stall};
        redirect_cnt_d = redirect_cnt_q + {{(CNT_W-1){1'b0}}, mode_br};

        if (mode_br) begin
            // A taken branch discards the stalled instruction, so any
            // pending bubbles are abandoned.
            state_d   = RUN;
            bub_cnt_d = 3'd0;
        end else if (mode_lu) begin
            if (state_q == LU_WAIT) begin
                if (bub_cnt_q <= 3'd1) begin
                    state_d   = RUN;
                    bub_cnt_d = 3'd0;
                end else begin
                    bub_cnt_d = bub_cnt_q - 3'd1;
                end
            end else if (MULTI_BUBBLE) begin
                state_d   = LU_WAIT;
                bub_cnt_d = BUB_INIT;
            end
        end
        // mode_mem: FSM and bubble count keep their values (defaults).
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            bub_cnt_q      <= 3'd0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            bub_cnt_q      <= bub_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl5.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl5
//
// Directed bench for pipeline_hazard_ctrl5. Two instances share stimulus:
//   dut  : LOAD_USE_BUBBLES=2, CNT_W=32
//   dut2 : LOAD_USE_BUBBLES=1, CNT_W=4 (single-bubble path, counter wrap)
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// Control vector bit order:
//   {pc_stall, stall_IF, stall_ID, stall_IDR, stall_EXB, stall_EXA,
//    flush_IF, flush_ID, flush_IDR, redirect_en, lu_active}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl5;

    localparam logic [10:0] C_NONE = 11'b000_000_000_00;
    localparam logic [10:0] C_LU   = 11'b111_000_001_00;
    localparam logic [10:0] C_LUW  = 11'b111_000_001_01;
    localparam logic [10:0] C_MEM  = 11'b111_111_000_00;
    localparam logic [10:0] C_MEMW = 11'b111_111_000_01;
    localparam logic [10:0] C_BR   = 11'b000_000_111_10;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_busy;
    logic       branch_taken_EXB;
    logic [4:0] rs1_ID, rs2_ID, rd_IDR;
    logic       rs1_used_ID, rs2_used_ID, rf_wr_en_IDR;
    logic [2:0] dm_rd_ctrl_IDR;

    logic        pc_stall, stall_IF, stall_ID, stall_IDR, stall_EXB, stall_EXA;
    logic        flush_IF, flush_ID, flush_IDR, redirect_en, lu_active;
    logic [31:0] stall_cycle_cnt, redirect_cnt;

    logic        pc_stall2, stall_IF2, stall_ID2, stall_IDR2, stall_EXB2, stall_EXA2;
    logic        flush_IF2, flush_ID2, flush_IDR2, redirect_en2, lu_active2;
    logic [3:0]  stall_cycle_cnt2, redirect_cnt2;

    logic [10:0] ctrl1, ctrl2;
    assign ctrl1 = {pc_stall, stall_IF, stall_ID, stall_IDR, stall_EXB, stall_EXA,
                    flush_IF, flush_ID, flush_IDR, redirect_en, lu_active};
    assign ctrl2 = {pc_stall2, stall_IF2, stall_ID2, stall_IDR2, stall_EXB2, stall_EXA2,
                    flush_IF2, flush_ID2, flush_IDR2, redirect_en2, lu_active2};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl5 #(.LOAD_USE_BUBBLES(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .mem_busy(mem_busy),
        .branch_taken_EXB(branch_taken_EXB),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_IDR(rd_IDR), .rf_wr_en_IDR(rf_wr_en_IDR), .dm_rd_ctrl_IDR(dm_rd_ctrl_IDR),
        .pc_stall(pc_stall), .stall_IF(stall_IF), .stall_ID(stall_ID),
        .stall_IDR(stall_IDR), .stall_EXB(stall_EXB), .stall_EXA(stall_EXA),
        .flush_IF(flush_IF), .flush_ID(flush_ID), .flush_IDR(flush_IDR),
        .redirect_en(redirect_en), .lu_active(lu_active),
        .stall_cycle_cnt(stall_cycle_cnt), .redirect_cnt(redirect_cnt)
    );

    pipeline_hazard_ctrl5 #(.LOAD_USE_BUBBLES(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .mem_busy(mem_busy),
        .branch_taken_EXB(branch_taken_EXB),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_IDR(rd_IDR), .rf_wr_en_IDR(rf_wr_en_IDR), .dm_rd_ctrl_IDR(dm_rd_ctrl_IDR),
        .pc_stall(pc_stall2), .stall_IF(stall_IF2), .stall_ID(stall_ID2),
        .stall_IDR(stall_IDR2), .stall_EXB(stall_EXB2), .stall_EXA(stall_EXA2),
        .flush_IF(flush_IF2), .flush_ID(flush_ID2), .flush_IDR(flush_IDR2),
        .redirect_en(redirect_en2), .lu_active(lu_active2),
        .stall_cycle_cnt(stall_cycle_cnt2), .redirect_cnt(redirect_cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check both instances' control vectors at the falling edge, then step.
    task automatic step_chk(input string tag, input logic [10:0] e1, input logic [10:0] e2);
        @(negedge clk);
        check({tag, "_d1"}, 64'(ctrl1), 64'(e1));
        check({tag, "_d2"}, 64'(ctrl2), 64'(e2));
        cyc();
    endtask

    task automatic clr_idr();
        rd_IDR         = 5'd0;
        rf_wr_en_IDR   = 1'b0;
        dm_rd_ctrl_IDR = 3'd0;
    endtask

    task automatic clr_all();
        clr_idr();
        rs1_ID = 5'd0; rs2_ID = 5'd0;
        rs1_used_ID = 1'b0; rs2_used_ID = 1'b0;
        mem_busy = 1'b0; branch_taken_EXB = 1'b0;
    endtask

    task automatic set_load(input logic [2:0] dm, input logic wr, input logic [4:0] rd);
        dm_rd_ctrl_IDR = dm; rf_wr_en_IDR = wr; rd_IDR = rd;
    endtask

    initial begin
        clr_all();

        // Reset overrides mem_busy and branch: controls forced low.
        reset = 1'b1; mem_busy = 1'b1; branch_taken_EXB = 1'b1;
        step_chk("rst_force", C_NONE, C_NONE);
        clr_all();
        step_chk("rst_hold", C_NONE, C_NONE);
        reset = 1'b0;
        @(negedge clk);
        check("rst_stall_cnt", 64'(stall_cycle_cnt), 64'd0);
        check("rst_redir_cnt", 64'(redirect_cnt), 64'd0);
        check("rst_ctrl", 64'(ctrl1), 64'(C_NONE));
        cyc();

        // Load x5 in IDR, ID reads rs1=5. IDR is flushed after detection.
        set_load(3'b010, 1'b1, 5'd5);
        rs1_ID = 5'd5; rs1_used_ID = 1'b1;
        step_chk("lu1_det", C_LU, C_LU);
        clr_idr();
        step_chk("lu1_wait", C_LUW, C_NONE);
        step_chk("lu1_done", C_NONE, C_NONE);
        @(negedge clk);
        check("lu1_stall_cnt", 64'(stall_cycle_cnt), 64'd2);
        check("lu1_stall_cnt2", 64'(stall_cycle_cnt2), 64'd1);
        cyc();

        // Non-hazard look-alikes.
        set_load(3'b010, 1'b1, 5'd0); rs1_ID = 5'd0; rs1_used_ID = 1'b1;
        step_chk("nohz_rd0", C_NONE, C_NONE);
        set_load(3'b010, 1'b1, 5'd7); rs1_ID = 5'd3; rs2_ID = 5'd7; rs2_used_ID = 1'b0;
        step_chk("nohz_rs2_unused", C_NONE, C_NONE);
        set_load(3'b000, 1'b1, 5'd7); rs2_used_ID = 1'b1;
        step_chk("nohz_not_load", C_NONE, C_NONE);
        set_load(3'b100, 1'b0, 5'd7);
        step_chk("nohz_no_wr", C_NONE, C_NONE);
        // rs2 match does stall.
        set_load(3'b001, 1'b1, 5'd7);
        step_chk("lu2_det", C_LU, C_LU);
        clr_idr();
        step_chk("lu2_wait", C_LUW, C_NONE);
        clr_all();

        // Taken branch for one cycle.
        branch_taken_EXB = 1'b1;
        step_chk("br_take", C_BR, C_BR);
        branch_taken_EXB = 1'b0;
        step_chk("br_after", C_NONE, C_NONE);
        @(negedge clk);
        check("br_redir_cnt", 64'(redirect_cnt), 64'd1);
        check("br_redir_cnt2", 64'(redirect_cnt2), 64'd1);
        check("br_stall_cnt", 64'(stall_cycle_cnt), 64'd4);
        cyc();

        // mem_busy for 3 cycles while in LU_WAIT with bub_cnt=1.
        set_load(3'b010, 1'b1, 5'd5); rs1_ID = 5'd5; rs1_used_ID = 1'b1;
        step_chk("mb_det", C_LU, C_LU);
        clr_idr();
        mem_busy = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("mb_hold", C_MEMW, C_MEM);
        mem_busy = 1'b0;
        step_chk("mb_last_bub", C_LUW, C_NONE);
        step_chk("mb_run", C_NONE, C_NONE);
        @(negedge clk);
        // 4 from earlier hazards + 5 for this one.
        check("mb_stall_cnt", 64'(stall_cycle_cnt), 64'd9);
        check("mb_stall_cnt2", 64'(stall_cycle_cnt2), 64'd6);
        cyc();
        clr_all();

        // Branch during mem_busy is ignored, accepted once released.
        mem_busy = 1'b1; branch_taken_EXB = 1'b1;
        step_chk("mbbr_hold0", C_MEM, C_MEM);
        step_chk("mbbr_hold1", C_MEM, C_MEM);
        mem_busy = 1'b0;
        step_chk("mbbr_take", C_BR, C_BR);
        branch_taken_EXB = 1'b0;
        @(negedge clk);
        check("mbbr_redir_cnt", 64'(redirect_cnt), 64'd2);
        check("mbbr_stall_cnt", 64'(stall_cycle_cnt), 64'd11);
        cyc();

        // Reset asserted during LU_WAIT.
        set_load(3'b010, 1'b1, 5'd9); rs2_ID = 5'd9; rs2_used_ID = 1'b1;
        step_chk("rlu_det", C_LU, C_LU);
        clr_all();
        @(negedge clk);
        check("rlu_in_wait", 64'(lu_active), 64'd1);
        reset = 1'b1;
        #1;
        check("rlu_force", 64'(ctrl1), 64'(C_NONE));
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check("rlu_after", 64'(ctrl1), 64'(C_NONE));
        check("rlu_stall_cnt", 64'(stall_cycle_cnt), 64'd0);
        check("rlu_redir_cnt", 64'(redirect_cnt), 64'd0);
        check("rlu_stall_cnt2", 64'(stall_cycle_cnt2), 64'd0);
        cyc();

        // Counter wrap on the 4-bit instance: 16 stall cycles -> 0.
        mem_busy = 1'b1;
        for (int i = 0; i < 16; i++) cyc();
        check("wrap_cnt2", 64'(stall_cycle_cnt2), 64'd0);
        check("wrap_cnt1", 64'(stall_cycle_cnt), 64'd16);
        cyc();
        check("wrap_cnt2_p1", 64'(stall_cycle_cnt2), 64'd1);
        mem_busy = 1'b0;
        step_chk("wrap_release", C_NONE, C_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl5.md
Name: pipeline_hazard_ctrl5

Overview:
Central stall/flush scheduler for the 5-stage pipeline (IF, ID, IDR, EXB, EXA/MEM/WB). It produces the per-register stall/hold and flush/clear controls consumed by each stage module, and the PC redirect enable for taken branches resolved in EXB. It contains a load-use bubble FSM with a parameterised bubble count, freezes the pipeline on memory back-pressure, and keeps free-running performance counters.

Parameters:
LOAD_USE_BUBBLES, 2, bubbles inserted per load-use hazard (legal range 1..7).
CNT_W, 32, width of performance counters.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
mem_busy  input  1  data memory not ready; whole pipeline must hold.
branch_taken_EXB  input  1  combinational taken/jump flag from EXB (evaluated on the _IDR registers).
rs1_ID, rs2_ID  input  5 each  source registers of the instruction held in the _ID registers.
rs1_used_ID, rs2_used_ID  input  1 each  source actually read.
rd_IDR  input  5  destination register of the instruction held in the _IDR registers.
rf_wr_en_IDR  input  1  its register-file write enable.
dm_rd_ctrl_IDR  input  3  its load control; non-zero means load.
pc_stall  output  1  hold PC.
stall_IF, stall_ID, stall_IDR, stall_EXB, stall_EXA  output  1 each  hold the named stage output registers.
flush_IF, flush_ID, flush_IDR  output  1 each  clear the named stage output registers (bubble) at the next edge.
redirect_en  output  1  PC loads branch target at the next edge.
lu_active  output  1  FSM not in RUN.
stall_cycle_cnt  output  CNT_W  cycles with pc_stall=1.
redirect_cnt  output  CNT_W  accepted redirects.

Behaviour:
- State: FSM {RUN, LU_WAIT}, 3-bit bubble counter bub_cnt, two counters. Control outputs are combinational from state and inputs, with zero latency.
- Reset (reset=1 at an edge): state=RUN, bub_cnt=0, both counters=0. While reset is high, all control outputs are forced to 0.
- Load-use hazard: lu_hz = (dm_rd_ctrl_IDR!=0) & rf_wr_en_IDR & (rd_IDR!=0) & ((rs1_used_ID & rs1_ID==rd_IDR) | (rs2_used_ID & rs2_ID==rd_IDR)).
- Priority each cycle is mem_busy > branch_taken_EXB > lu_hz/LU_WAIT > normal.
- mem_busy=1: pc_stall and all stall_* = 1; flush_* = 0; redirect_en = 0.
  - FSM state, bub_cnt and redirect_cnt are frozen.
  - A branch asserted during mem_busy is ignored. It reasserts after release because the _IDR registers are held.
- Taken branch (mem_busy=0, branch_taken_EXB=1):
  - redirect_en=1 and flush_IF=flush_ID=flush_IDR=1; all stall_* = 0.
  - State is forced to RUN and bub_cnt to 0. redirect_cnt increments.
- RUN with lu_hz=1 (no branch, no mem_busy):
  - pc_stall=stall_IF=stall_ID=1 and flush_IDR=1.
  - If LOAD_USE_BUBBLES>1: state goes to LU_WAIT and bub_cnt=LOAD_USE_BUBBLES-1. Otherwise the state stays RUN.
- LU_WAIT (no branch, no mem_busy):
  - Same outputs as hazard detection, and bub_cnt decrements.
  - When bub_cnt==1 at the edge, return to RUN with bub_cnt=0.
  - Total bubbles inserted per hazard = LOAD_USE_BUBBLES exactly. lu_hz is not re-evaluated inside LU_WAIT.
- Normal: all controls 0.
- Whenever pc_stall=1 outside reset, stall_cycle_cnt increments. Counters wrap modulo 2^CNT_W.
- lu_active = (state==LU_WAIT).
- Reset mid-LU_WAIT or mid-mem_busy: controls are 0 immediately and the FSM is in RUN after the edge.
- A stall_* signal and a flush_* signal for the same register are never both 1.

Test Plan:
- Load x5 in _IDR, ID instruction uses rs1=5, LOAD_USE_BUBBLES=2 -> 2 consecutive cycles of pc_stall=stall_ID=flush_IDR=1, lu_active high for 1 cycle, then all 0; stall_cycle_cnt=2.
- Load with rd_IDR=0, or rs2_used_ID=0 with rs2 matching -> no stall; all controls 0.
- branch_taken_EXB=1 for 1 cycle -> redirect_en=flush_IF=flush_ID=flush_IDR=1 that cycle only; redirect_cnt=1.
- mem_busy high 3 cycles while in LU_WAIT with bub_cnt=1 -> all stall_*=1 and no flush for 3 cycles; afterwards exactly 1 more bubble cycle, then RUN; stall_cycle_cnt=5 total.
- mem_busy=1 and branch_taken_EXB=1 together for 2 cycles, then mem_busy=0 -> redirect_en=0 for 2 cycles, then 1 for 1 cycle; redirect_cnt=1.
- Reset asserted during LU_WAIT -> outputs 0 that cycle; next cycle lu_active=0 and counters=0. Preload stall_cycle_cnt near 2^32-1 via forced stalls (or CNT_W=4) -> wraps to 0.
